// File: rtl/svcs_sched_pkg.sv
// Shared types and constants for the SVCS round-robin transaction scheduler.
package svcs_sched_pkg;

    localparam int SVCS_MAX_SIZE = 4096;
    localparam int SVCS_DW       = 32;
    localparam int SVCS_CW       = $clog2(SVCS_MAX_SIZE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_H_TYPE,
        S_H_ID,
        S_H_DTYPE,
        S_H_NPL,
        S_PAYLOAD
    } svcs_sched_state_e;

    typedef struct packed {
        logic [SVCS_DW-1:0] trnx_type;
        logic [SVCS_DW-1:0] trnx_id;
        logic [SVCS_DW-1:0] data_type;
        logic [SVCS_CW-1:0] n_payloads;
    } svcs_hdr_t;

endpackage

// File: rtl/svcs_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module svcs_rr_arbiter
    import svcs_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt,
    output logic                 any
);

    localparam int GW = $clog2(N);

    logic [GW-1:0] w_idx;

    // Scan from the farthest offset down so the offset nearest ptr wins last.
    always_comb begin
        gnt   = '0;
        any   = 1'b0;
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = GW'((int'(ptr) + i) % N);
            if (req[w_idx]) begin
                gnt = w_idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/svcs_trnx_sched.sv
// Round-robin scheduler that serialises N_REQ requesters into one stream of
// four header words followed by n_payloads payload words per transaction.
module svcs_trnx_sched
    import svcs_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DW           = SVCS_DW,
    parameter int MAX_PAYLOADS = SVCS_MAX_SIZE,
    parameter int CW           = $clog2(MAX_PAYLOADS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DW-1:0]      req_type,
    input  logic [N_REQ*DW-1:0]      req_id,
    input  logic [N_REQ*DW-1:0]      req_dtype,
    input  logic [N_REQ*CW-1:0]      req_npl,
    output logic [N_REQ-1:0]         req_ack,
    output logic [N_REQ-1:0]         req_err,
    input  logic [N_REQ-1:0]         pl_valid,
    input  logic [N_REQ*DW-1:0]      pl_data,
    output logic [N_REQ-1:0]         pl_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic                     out_hdr,
    output logic                     out_last,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     trnx_done
);

    localparam int GW = $clog2(N_REQ);

    svcs_sched_state_e r_state, w_state_nx;
    svcs_hdr_t         r_hdr, w_hdr_nx;
    logic [GW-1:0]     r_rr_ptr, w_rr_ptr_nx;
    logic [GW-1:0]     r_grant, w_grant_nx;
    logic [CW-1:0]     r_rem, w_rem_nx;
    logic              r_out_valid, w_out_valid_nx;
    logic              r_out_hdr, w_out_hdr_nx;
    logic              r_out_last, w_out_last_nx;
    logic [DW-1:0]     r_out_data, w_out_data_nx;
    logic [N_REQ-1:0]  r_req_ack, w_req_ack_nx;
    logic [N_REQ-1:0]  r_req_err, w_req_err_nx;
    logic              r_trnx_done, w_trnx_done_nx;
    logic              r_busy, w_busy_nx;

    logic [N_REQ-1:0]  w_req_elig;
    logic [GW-1:0]     w_win, w_win_inc, w_grant_inc;
    logic              w_any;
    logic [CW-1:0]     w_win_npl;
    logic              w_hs;
    logic              w_pl_xfer;

    // A requester sees its ack one cycle late, so it is masked for that cycle
    // to avoid being picked twice when its header was rejected.
    assign w_req_elig = req_valid & ~r_req_ack;

    svcs_rr_arbiter #(.N(N_REQ)) u_arb (
        .req (w_req_elig),
        .ptr (r_rr_ptr),
        .gnt (w_win),
        .any (w_any)
    );

    assign w_win_npl   = req_npl[w_win*CW +: CW];
    assign w_win_inc   = (w_win == GW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    assign w_grant_inc = (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
    assign w_hs        = r_out_valid && out_ready;
    assign w_pl_xfer   = pl_valid[r_grant] && out_ready;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nx     = r_state;
        w_hdr_nx       = r_hdr;
        w_rr_ptr_nx    = r_rr_ptr;
        w_grant_nx     = r_grant;
        w_rem_nx       = r_rem;
        w_out_valid_nx = r_out_valid;
        w_out_hdr_nx   = r_out_hdr;
        w_out_last_nx  = r_out_last;
        w_out_data_nx  = r_out_data;
        w_req_ack_nx   = '0;
        w_req_err_nx   = '0;
        w_trnx_done_nx = 1'b0;
        w_busy_nx      = r_busy;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_req_ack_nx[w_win] = 1'b1;
                    if (w_win_npl > CW'(MAX_PAYLOADS)) begin
                        w_req_err_nx[w_win] = 1'b1;
                        w_rr_ptr_nx         = w_win_inc;
                    end else begin
                        w_hdr_nx.trnx_type  = SVCS_DW'(req_type[w_win*DW +: DW]);
                        w_hdr_nx.trnx_id    = SVCS_DW'(req_id[w_win*DW +: DW]);
                        w_hdr_nx.data_type  = SVCS_DW'(req_dtype[w_win*DW +: DW]);
                        w_hdr_nx.n_payloads = SVCS_CW'(w_win_npl);
                        w_grant_nx          = w_win;
                        w_state_nx          = S_H_TYPE;
                        w_out_valid_nx      = 1'b1;
                        w_out_hdr_nx        = 1'b1;
                        w_out_last_nx       = 1'b0;
                        w_out_data_nx       = DW'(req_type[w_win*DW +: DW]);
                        w_busy_nx           = 1'b1;
                    end
                end
            end
            S_H_TYPE: if (w_hs) begin
                w_state_nx    = S_H_ID;
                w_out_data_nx = DW'(r_hdr.trnx_id);
            end
            S_H_ID: if (w_hs) begin
                w_state_nx    = S_H_DTYPE;
                w_out_data_nx = DW'(r_hdr.data_type);
            end
            S_H_DTYPE: if (w_hs) begin
                w_state_nx    = S_H_NPL;
                w_out_data_nx = DW'(r_hdr.n_payloads);
                w_out_last_nx = (r_hdr.n_payloads == '0);
            end
            S_H_NPL: if (w_hs) begin
                w_out_valid_nx = 1'b0;
                w_out_hdr_nx   = 1'b0;
                w_out_last_nx  = 1'b0;
                if (r_hdr.n_payloads == '0) begin
                    w_state_nx     = S_IDLE;
                    w_trnx_done_nx = 1'b1;
                    w_busy_nx      = 1'b0;
                    w_rr_ptr_nx    = w_grant_inc;
                end else begin
                    w_state_nx = S_PAYLOAD;
                    w_rem_nx   = CW'(r_hdr.n_payloads);
                end
            end
            S_PAYLOAD: if (w_pl_xfer) begin
                w_rem_nx = r_rem - 1'b1;
                if (r_rem == CW'(1)) begin
                    w_state_nx     = S_IDLE;
                    w_trnx_done_nx = 1'b1;
                    w_busy_nx      = 1'b0;
                    w_rr_ptr_nx    = w_grant_inc;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments and a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hdr       <= '0;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_hdr   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_req_ack   <= '0;
            r_req_err   <= '0;
            r_trnx_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_hdr       <= w_hdr_nx;
            r_rr_ptr    <= w_rr_ptr_nx;
            r_grant     <= w_grant_nx;
            r_rem       <= w_rem_nx;
            r_out_valid <= w_out_valid_nx;
            r_out_hdr   <= w_out_hdr_nx;
            r_out_last  <= w_out_last_nx;
            r_out_data  <= w_out_data_nx;
            r_req_ack   <= w_req_ack_nx;
            r_req_err   <= w_req_err_nx;
            r_trnx_done <= w_trnx_done_nx;
            r_busy      <= w_busy_nx;
        end
    end

    // Header words come from registers; payload words pass straight through.
    always_comb begin
        pl_ready = '0;
        if (r_state == S_PAYLOAD) begin
            pl_ready[r_grant] = out_ready;
        end
    end

    assign out_valid = (r_state == S_PAYLOAD) ? pl_valid[r_grant]          : r_out_valid;
    assign out_data  = (r_state == S_PAYLOAD) ? pl_data[r_grant*DW +: DW]  : r_out_data;
    assign out_hdr   = (r_state == S_PAYLOAD) ? 1'b0                       : r_out_hdr;
    assign out_last  = (r_state == S_PAYLOAD) ? (r_rem == CW'(1))          : r_out_last;

    assign req_ack   = r_req_ack;
    assign req_err   = r_req_err;
    assign busy      = r_busy;
    assign grant_id  = r_grant;
    assign trnx_done = r_trnx_done;

endmodule

// File: tb/tb_svcs_trnx_sched.sv
// Scoreboard bench for svcs_trnx_sched: stimulus queues expected words and
// grants, independent monitors compare whatever the DUT presents.
module tb_svcs_trnx_sched;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 13;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_type = '0;
    logic [N*DW-1:0] req_id = '0;
    logic [N*DW-1:0] req_dtype = '0;
    logic [N*CW-1:0] req_npl = '0;
    logic [N-1:0]    req_ack, req_err;
    logic [N-1:0]    pl_valid = '0;
    logic [N*DW-1:0] pl_data = '0;
    logic [N-1:0]    pl_ready;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_data;
    logic            out_hdr, out_last, busy, trnx_done;
    logic [1:0]      grant_id;

    svcs_trnx_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_type(req_type), .req_id(req_id),
        .req_dtype(req_dtype), .req_npl(req_npl),
        .req_ack(req_ack), .req_err(req_err),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_hdr(out_hdr), .out_last(out_last), .busy(busy),
        .grant_id(grant_id), .trnx_done(trnx_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic hdr; logic last; } word_t;
    typedef struct { logic [31:0] t; logic [31:0] id; logic [31:0] dt; logic [12:0] npl; } hdr_t;
    typedef struct { int idx; logic err; } gnt_t;

    word_t       exp_q[$];
    hdr_t        hdr_q[N][$];
    logic [31:0] pl_q[N][$];
    gnt_t        gnt_q[$];
    int          ack_cyc[$];

    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   pl_xfers = 0;
    int   plr_seen = 0;
    bit   gap_mode = 1'b0;
    bit   toggle = 1'b0;
    bit   watch_plr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int r, input logic [31:0] t, input logic [31:0] id,
                         input logic [31:0] dt, input int npl, input logic [31:0] base);
        hdr_t h;
        gnt_t g;
        h.t = t; h.id = id; h.dt = dt; h.npl = 13'(npl);
        hdr_q[r].push_back(h);
        g.idx = r; g.err = (npl > 4096);
        gnt_q.push_back(g);
        if (!g.err) begin
            exp_q.push_back('{t, 1'b1, 1'b0});
            exp_q.push_back('{id, 1'b1, 1'b0});
            exp_q.push_back('{dt, 1'b1, 1'b0});
            exp_q.push_back('{32'(npl), 1'b1, npl == 0});
            for (int j = 0; j < npl; j++) begin
                pl_q[r].push_back(base + 32'(j));
                exp_q.push_back('{base + 32'(j), 1'b0, j == npl - 1});
            end
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (toggle) out_ready = ~out_ready;
            if (exp_q.size() == 0 && gnt_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_timeout"}, 32'd1, 32'd0);
        tick();
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_hdr"},   32'(out_hdr), 0);
        check({tag, "_out_last"},  32'(out_last), 0);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_req_ack"},   32'(req_ack), 0);
        check({tag, "_req_err"},   32'(req_err), 0);
        check({tag, "_pl_ready"},  32'(pl_ready), 0);
        check({tag, "_trnx_done"}, 32'(trnx_done), 0);
        check({tag, "_grant_id"},  32'(grant_id), 0);
    endtask

    // Requester model: presents queued headers/payloads, pops on ack/transfer,
    // holds a payload word while it is offered but not taken.
    logic [N-1:0] pl_x, ack_x;
    always begin
        @(negedge clk);
        pl_x  = pl_valid & pl_ready;
        ack_x = req_ack;
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            if (ack_x[i] && hdr_q[i].size() != 0) void'(hdr_q[i].pop_front());
            req_valid[i] = (hdr_q[i].size() != 0);
            req_type[i*DW +: DW]  = req_valid[i] ? hdr_q[i][0].t   : '0;
            req_id[i*DW +: DW]    = req_valid[i] ? hdr_q[i][0].id  : '0;
            req_dtype[i*DW +: DW] = req_valid[i] ? hdr_q[i][0].dt  : '0;
            req_npl[i*CW +: CW]   = req_valid[i] ? hdr_q[i][0].npl : '0;
            if (pl_x[i] && pl_q[i].size() != 0) void'(pl_q[i].pop_front());
            pl_valid[i] = (pl_q[i].size() != 0) &&
                          ((pl_valid[i] && !pl_x[i]) || !(gap_mode && (cyc % 3 == 1)));
            pl_data[i*DW +: DW] = (pl_q[i].size() != 0) ? pl_q[i][0] : '0;
        end
    end

    // Stream monitor.
    word_t       w_exp;
    bit          done_exp = 1'b0;
    bit          done_nx;
    bit          stall_v = 1'b0;
    logic [31:0] st_d;
    logic        st_h, st_l;
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_exp || trnx_done) check("trnx_done", 32'(trnx_done), 32'(done_exp));
            done_nx = 1'b0;
            if (stall_v && out_valid) begin
                check("stall_data", out_data, st_d);
                check("stall_hdr", 32'(out_hdr), 32'(st_h));
                check("stall_last", 32'(out_last), 32'(st_l));
            end
            if (watch_plr && pl_ready != 0) plr_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", out_data, 32'hdead_beef);
                end else begin
                    w_exp = exp_q.pop_front();
                    check("word_data", out_data, w_exp.d);
                    check("word_hdr", 32'(out_hdr), 32'(w_exp.hdr));
                    check("word_last", 32'(out_last), 32'(w_exp.last));
                    done_nx = w_exp.last;
                end
                if (!out_hdr) pl_xfers++;
            end
            stall_v  = out_valid && !out_ready;
            st_d     = out_data;
            st_h     = out_hdr;
            st_l     = out_last;
            done_exp = done_nx;
        end else begin
            done_exp = 1'b0;
            stall_v  = 1'b0;
        end
    end

    // Grant monitor.
    gnt_t g_ack;
    always @(negedge clk) begin
        if (rst_n && (req_err & ~req_ack) != 0) check("err_without_ack", 32'(req_err), 32'(req_ack));
        if (rst_n && req_ack != 0) begin
            for (int i = 0; i < N; i++) begin
                if (req_ack[i]) begin
                    ack_cyc.push_back(cyc);
                    if (gnt_q.size() == 0) begin
                        check("unexpected_ack", 32'(i), 32'hffff_ffff);
                    end else begin
                        g_ack = gnt_q.pop_front();
                        check("grant_order", 32'(i), 32'(g_ack.idx));
                        check("req_err", 32'(req_err[i]), 32'(g_ack.err));
                        if (g_ack.err) begin
                            check("err_no_output", 32'(out_valid), 0);
                        end else begin
                            check("first_hdr_valid", 32'(out_valid && out_hdr), 1);
                            check("grant_id", 32'(grant_id), 32'(i));
                            check("busy_on_grant", 32'(busy), 1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    int c0;
    initial begin
        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // 1: single request
        ack_cyc.delete();
        issue(0, 32'h11, 32'h22, 32'h33, 3, 32'hA0);
        c0 = cyc;
        wait_done("t1", 100);
        check("t1_ack_count", 32'(ack_cyc.size()), 1);
        if (ack_cyc.size() > 0) check("t1_grant_latency", 32'(ack_cyc[0] - c0), 1);

        // 2: fairness from rr_ptr = 0
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        ack_cyc.delete();
        issue(0, 32'h100, 32'h101, 32'h102, 1, 32'hB0);
        issue(1, 32'h110, 32'h111, 32'h112, 1, 32'hB1);
        issue(2, 32'h120, 32'h121, 32'h122, 1, 32'hB2);
        issue(3, 32'h130, 32'h131, 32'h132, 1, 32'hB3);
        issue(0, 32'h140, 32'h141, 32'h142, 1, 32'hB4);
        wait_done("t2", 200);
        check("t2_ack_count", 32'(ack_cyc.size()), 5);
        for (int k = 1; k < ack_cyc.size(); k++)
            check("t2_period", 32'(ack_cyc[k] - ack_cyc[k-1]), 6);

        // 3: zero payloads
        watch_plr = 1'b1;
        plr_seen  = 0;
        issue(1, 32'h211, 32'h222, 32'h233, 0, 32'h0);
        wait_done("t3", 100);
        check("t3_no_pl_ready", 32'(plr_seen), 0);
        watch_plr = 1'b0;

        // 4: illegal count on requester 2, next grant 3 then 0
        issue(2, 32'h311, 32'h322, 32'h333, 4097, 32'h0);
        issue(3, 32'h341, 32'h342, 32'h343, 1, 32'hC3);
        issue(0, 32'h351, 32'h352, 32'h353, 1, 32'hC0);
        wait_done("t4", 200);

        // 5: backpressure 1010 with payload gaps
        gap_mode = 1'b1;
        toggle   = 1'b1;
        issue(2, 32'h411, 32'h422, 32'h433, 5, 32'hD0);
        wait_done("t5", 300);
        gap_mode  = 1'b0;
        toggle    = 1'b0;
        out_ready = 1'b1;
        tick();

        // 6: reset in PAYLOAD with rem = 2, then rr_ptr must restart at 0
        pl_xfers = 0;
        issue(1, 32'h511, 32'h522, 32'h533, 4, 32'hE0);
        for (int n = 0; n < 100 && pl_xfers < 2; n++) tick();
        check("t6_reached_payload", 32'(pl_xfers), 2);
        rst_n = 1'b0;
        exp_q.delete();
        gnt_q.delete();
        for (int i = 0; i < N; i++) begin
            pl_q[i].delete();
            hdr_q[i].delete();
        end
        tick();
        @(negedge clk);
        check_zero("t6_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        issue(0, 32'h611, 32'h622, 32'h633, 2, 32'hF0);
        issue(3, 32'h641, 32'h642, 32'h643, 1, 32'hF3);
        wait_done("t6", 200);

        check("leftover_words", 32'(exp_q.size()), 0);
        check("leftover_grants", 32'(gnt_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/svcs_trnx_sched.md
# svcs_trnx_sched

Round-robin transaction scheduler for SVCS handshake traffic. It shares one outbound word stream, toward the socket bridge, between `N_REQ` requesters. Each granted requester's transaction goes out as a four-word header (`trnx_type`, `trnx_id`, `data_type`, `n_payloads`) followed by exactly `n_payloads` payload words. Transactions are never interleaved.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8)
- `DW`, 32: header and payload word width
- `MAX_PAYLOADS`, 4096: largest legal `n_payloads`, equal to the SVCS max size
- `CW`, `$clog2(MAX_PAYLOADS+1)`: width of the payload count (13 at default)

Ports:
- `clk` in, 1: single clock
- `rst_n` in, 1: synchronous, active-low reset
- `req_valid` in, `N_REQ`: requester i has a header pending
- `req_type` in, `N_REQ*DW`: flattened `trnx_type`, slice i belongs to requester i
- `req_id` in, `N_REQ*DW`: flattened `trnx_id`
- `req_dtype` in, `N_REQ*DW`: flattened `data_type`
- `req_npl` in, `N_REQ*CW`: flattened `n_payloads`
- `req_ack` out, `N_REQ`: one-cycle pulse; header of requester i captured
- `req_err` out, `N_REQ`: one-cycle pulse, coincident with `req_ack`; header rejected
- `pl_valid` in, `N_REQ`: payload word available from requester i
- `pl_data` in, `N_REQ*DW`: flattened payload data
- `pl_ready` out, `N_REQ`: payload word of requester i consumed this cycle
- `out_valid` out, 1: stream word valid
- `out_ready` in, 1: downstream accepts the word
- `out_data` out, `DW`: stream word
- `out_hdr` out, 1: current word is a header word
- `out_last` out, 1: final word of the transaction
- `busy` out, 1: a transaction is in progress
- `grant_id` out, `$clog2(N_REQ)`: index of the requester being served
- `trnx_done` out, 1: one-cycle pulse after the last word is accepted

## Operation
States: IDLE, H_TYPE, H_ID, H_DTYPE, H_NPL, PAYLOAD.

- **IDLE arbitration**
  - Round-robin over `req_valid`, starting at `rr_ptr`.
  - On the winner w, latch its type, id, data type and payload count; pulse `req_ack[w]`; set `grant_id = w`.
  - Go to H_TYPE.
- **Illegal header**: if `req_npl[w] > MAX_PAYLOADS`:
  - pulse `req_ack[w]` and `req_err[w]`;
  - emit nothing and stay in IDLE;
  - advance `rr_ptr` to w+1.
- **Header states**: each H_* state drives `out_valid=1`, `out_hdr=1` and the matching latched field. `n_payloads` is zero-extended to `DW`. Advance on `out_valid && out_ready`.
- **H_NPL exit**:
  - count = 0: `out_last=1` on the H_NPL word; go to IDLE.
  - count > 0: load the down-counter `rem = count`; go to PAYLOAD.
- **PAYLOAD** passes through requester w:
  - `out_valid = pl_valid[w]`, `out_data = pl_data[w]`;
  - `pl_ready[w] = out_ready`; all other `pl_ready` bits are 0;
  - `out_last = (rem == 1)`;
  - each transfer decrements `rem`; the transfer with `rem == 1` returns the FSM to IDLE.
- **Completion**: on leaving to IDLE after the last accepted word, pulse `trnx_done` and set `rr_ptr = w+1` (mod `N_REQ`).
- **Idle requesters**: ungranted `req_valid` bits wait; `req_ack` is never issued to them.
- **Simultaneous requests**: the priority order is `rr_ptr`, `rr_ptr+1`, and so on; lower indices win only through that ordering.

## Timing
- **Reset values**: state IDLE, `rr_ptr=0`, `rem=0`, `grant_id=0`. All outputs 0: `out_valid`, `out_hdr`, `out_last`, `busy`, `req_ack`, `req_err`, `pl_ready`, `trnx_done`.
- **Grant latency**: `req_valid` sampled high in IDLE at edge k gives `req_ack` high during cycle k+1 and the first header word valid in cycle k+1.
- **Output registering**: header-phase `out_*` are registered. Payload phase is a combinational pass-through of requester w, with no added latency.
- **Backpressure**: while `out_valid && !out_ready`, `out_data`, `out_hdr` and `out_last` hold stable.
- **Throughput**: minimum cost per transaction is 4 + `n_payloads` transfer cycles plus 1 IDLE cycle.
- **busy**: 1 from cycle k+1 until the cycle after the last transfer.
- **Reset mid-transaction**: abandon the transaction immediately; no `trnx_done`; the stream simply stops, and the downstream resynchronises on the next `out_hdr` word.

## Structure
- **Package `svcs_sched_pkg`**:
  - state enum `svcs_sched_state_e`;
  - constant `SVCS_MAX_SIZE = 4096`;
  - struct `svcs_hdr_t` holding type, id and dtype as `DW` each, plus npl as `CW`.
- **Sub-module `svcs_rr_arbiter`**: parameter `N`; inputs `req[N]` and `ptr`; outputs `gnt` index and `any`. Purely combinational.

## Test plan
1. **Single request**: requester 0 sends type=0x11, id=0x22, dtype=0x33, npl=3 with `out_ready` held 1. Expect stream 0x11, 0x22, 0x33, 0x3 (`out_hdr=1`), then payloads P0..P2 (`out_hdr=0`), `out_last` on P2, and `trnx_done` one cycle later.
2. **Fairness**: all 4 requesters valid continuously, each npl=1. Expect grant order 0, 1, 2, 3, 0, and each transaction takes 6 cycles.
3. **Zero payloads**: npl=0. Expect exactly 4 words with `out_last` on the 4th, and no `pl_ready` asserted.
4. **Illegal count**: npl=4097 on requester 2. Expect `req_ack[2]` and `req_err[2]` pulsed together, `out_valid` stays 0, and the next grant goes to requester 3.
5. **Backpressure and stalls**: `out_ready` toggles 1010 while `pl_valid` has gaps, npl=5. Expect all 5 payloads in order, no duplicates, and `out_data` stable during each stall.
6. **Reset mid-transaction**: `rst_n` low during PAYLOAD with `rem=2`. Expect all outputs 0 next cycle, `rr_ptr=0`, and a fresh request afterwards is served normally.
